// File: rtl/aes_inv_cipher_ctrl.sv
// aes_inv_cipher_ctrl
// Iterative AES-128 decryption round controller. One ciphertext block is
// accepted over a valid/ready handshake. The block is then run through the
// shared inverse-round datapath one round per clock, and the plaintext is
// presented on a held valid/ready output. Round keys come from an external
// key-schedule store by index, and that lookup is combinational.
//
// Ports
//   clk        system clock, rising edge
//   n_rst      asynchronous active-low reset
//   in_valid   ciphertext valid
//   in_ready   controller can accept ciphertext (IDLE only)
//   in_data    ciphertext, byte 0 at [127:120], column-major
//   key_idx    round-key index requested this cycle (from state/round only)
//   round_key  round key for key_idx, valid in the same cycle
//   out_valid  plaintext valid (DONE)
//   out_ready  consumer accepts plaintext
//   out_data   plaintext, which is the state register
//   busy       high in ROUND or FINAL
//
// state | meaning
// ------+---------------------------------------------------------------
// IDLE  | ready for a block; key 10 is applied as the initial AddRoundKey
// ROUND | full inverse round with key rnd (9 down to 1)
// FINAL | last round with key 0, no InvMixColumns
// DONE  | plaintext held on out_data until out_ready

module aes_inv_cipher_ctrl #(
  parameter int NUM_ROUNDS = 10,
  parameter int KEY_IDX_W  = 4
) (
  input  logic                 clk,
  input  logic                 n_rst,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [127:0]         in_data,
  output logic [KEY_IDX_W-1:0] key_idx,
  input  logic [127:0]         round_key,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [127:0]         out_data,
  output logic                 busy
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ROUND = 2'd1,
    S_FINAL = 2'd2,
    S_DONE  = 2'd3
  } state_e;

  // Inverse S-box. Entry i sits at index i of the packed array.
  localparam logic [0:255][7:0] INV_SBOX = {
    8'h52, 8'h09, 8'h6a, 8'hd5, 8'h30, 8'h36, 8'ha5, 8'h38, 8'hbf, 8'h40, 8'ha3, 8'h9e, 8'h81, 8'hf3, 8'hd7, 8'hfb,
    8'h7c, 8'he3, 8'h39, 8'h82, 8'h9b, 8'h2f, 8'hff, 8'h87, 8'h34, 8'h8e, 8'h43, 8'h44, 8'hc4, 8'hde, 8'he9, 8'hcb,
    8'h54, 8'h7b, 8'h94, 8'h32, 8'ha6, 8'hc2, 8'h23, 8'h3d, 8'hee, 8'h4c, 8'h95, 8'h0b, 8'h42, 8'hfa, 8'hc3, 8'h4e,
    8'h08, 8'h2e, 8'ha1, 8'h66, 8'h28, 8'hd9, 8'h24, 8'hb2, 8'h76, 8'h5b, 8'ha2, 8'h49, 8'h6d, 8'h8b, 8'hd1, 8'h25,
    8'h72, 8'hf8, 8'hf6, 8'h64, 8'h86, 8'h68, 8'h98, 8'h16, 8'hd4, 8'ha4, 8'h5c, 8'hcc, 8'h5d, 8'h65, 8'hb6, 8'h92,
    8'h6c, 8'h70, 8'h48, 8'h50, 8'hfd, 8'hed, 8'hb9, 8'hda, 8'h5e, 8'h15, 8'h46, 8'h57, 8'ha7, 8'h8d, 8'h9d, 8'h84,
    8'h90, 8'hd8, 8'hab, 8'h00, 8'h8c, 8'hbc, 8'hd3, 8'h0a, 8'hf7, 8'he4, 8'h58, 8'h05, 8'hb8, 8'hb3, 8'h45, 8'h06,
    8'hd0, 8'h2c, 8'h1e, 8'h8f, 8'hca, 8'h3f, 8'h0f, 8'h02, 8'hc1, 8'haf, 8'hbd, 8'h03, 8'h01, 8'h13, 8'h8a, 8'h6b,
    8'h3a, 8'h91, 8'h11, 8'h41, 8'h4f, 8'h67, 8'hdc, 8'hea, 8'h97, 8'hf2, 8'hcf, 8'hce, 8'hf0, 8'hb4, 8'he6, 8'h73,
    8'h96, 8'hac, 8'h74, 8'h22, 8'he7, 8'had, 8'h35, 8'h85, 8'he2, 8'hf9, 8'h37, 8'he8, 8'h1c, 8'h75, 8'hdf, 8'h6e,
    8'h47, 8'hf1, 8'h1a, 8'h71, 8'h1d, 8'h29, 8'hc5, 8'h89, 8'h6f, 8'hb7, 8'h62, 8'h0e, 8'haa, 8'h18, 8'hbe, 8'h1b,
    8'hfc, 8'h56, 8'h3e, 8'h4b, 8'hc6, 8'hd2, 8'h79, 8'h20, 8'h9a, 8'hdb, 8'hc0, 8'hfe, 8'h78, 8'hcd, 8'h5a, 8'hf4,
    8'h1f, 8'hdd, 8'ha8, 8'h33, 8'h88, 8'h07, 8'hc7, 8'h31, 8'hb1, 8'h12, 8'h10, 8'h59, 8'h27, 8'h80, 8'hec, 8'h5f,
    8'h60, 8'h51, 8'h7f, 8'ha9, 8'h19, 8'hb5, 8'h4a, 8'h0d, 8'h2d, 8'he5, 8'h7a, 8'h9f, 8'h93, 8'hc9, 8'h9c, 8'hef,
    8'ha0, 8'he0, 8'h3b, 8'h4d, 8'hae, 8'h2a, 8'hf5, 8'hb0, 8'hc8, 8'heb, 8'hbb, 8'h3c, 8'h83, 8'h53, 8'h99, 8'h61,
    8'h17, 8'h2b, 8'h04, 8'h7e, 8'hba, 8'h77, 8'hd6, 8'h26, 8'he1, 8'h69, 8'h14, 8'h63, 8'h55, 8'h21, 8'h0c, 8'h7d
  };

  localparam logic [KEY_IDX_W-1:0] LAST_KEY  = KEY_IDX_W'(NUM_ROUNDS);
  localparam logic [KEY_IDX_W-1:0] FIRST_RND = KEY_IDX_W'(NUM_ROUNDS - 1);

  // ---------------------------------------------------------------------
  // Inverse-round datapath functions
  // ---------------------------------------------------------------------

  // Byte (r,c) sits at flat index 4*c + r. Row r rotates right by r columns.
  function automatic logic [127:0] inv_shift_rows(input logic [127:0] s);
    logic [127:0] o;
    o = '0;
    for (int c = 0; c < 4; c++) begin
      for (int r = 0; r < 4; r++) begin
        o[127-8*(4*c+r) -: 8] = s[127-8*(4*((c+4-r)%4)+r) -: 8];
      end
    end
    return o;
  endfunction

  // Byte order does not matter for a byte-wise substitution.
  function automatic logic [127:0] inv_sub_bytes(input logic [127:0] s);
    logic [127:0] o;
    o = '0;
    for (int i = 0; i < 16; i++) begin
      o[8*i +: 8] = INV_SBOX[s[8*i +: 8]];
    end
    return o;
  endfunction

  function automatic logic [7:0] xtime(input logic [7:0] b);
    return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
  endfunction

  // Multiplies one column by the {0e,0b,0d,09} circulant. The 9/b/d/e
  // multiples are built from the shared x2/x4/x8 doubling chain.
  function automatic logic [31:0] inv_mix_col(input logic [31:0] col);
    logic [3:0][7:0] a, m9, m11, m13, m14;
    logic [7:0]      x2, x4, x8;
    a = '0; m9 = '0; m11 = '0; m13 = '0; m14 = '0;
    for (int i = 0; i < 4; i++) begin
      a[i]   = col[31-8*i -: 8];
      x2     = xtime(a[i]);
      x4     = xtime(x2);
      x8     = xtime(x4);
      m9[i]  = x8 ^ a[i];
      m11[i] = x8 ^ x2 ^ a[i];
      m13[i] = x8 ^ x4 ^ a[i];
      m14[i] = x8 ^ x4 ^ x2;
    end
    return {m14[0] ^ m11[1] ^ m13[2] ^ m9[3],
            m9[0]  ^ m14[1] ^ m11[2] ^ m13[3],
            m13[0] ^ m9[1]  ^ m14[2] ^ m11[3],
            m11[0] ^ m13[1] ^ m9[2]  ^ m14[3]};
  endfunction

  function automatic logic [127:0] inv_mix_columns(input logic [127:0] s);
    logic [127:0] o;
    o = '0;
    for (int c = 0; c < 4; c++) begin
      o[127-32*c -: 32] = inv_mix_col(s[127-32*c -: 32]);
    end
    return o;
  endfunction

  // ---------------------------------------------------------------------
  // State and datapath
  // ---------------------------------------------------------------------
  state_e               state_q, state_d;
  logic [KEY_IDX_W-1:0] rnd_q, rnd_d;
  logic [127:0]         aes_state_q, aes_state_d;

  logic [127:0] isr_isb;
  logic [127:0] ark;
  logic [127:0] imc;

  // FINAL takes ark directly. ROUND adds InvMixColumns after the key XOR.
  assign isr_isb = inv_sub_bytes(inv_shift_rows(aes_state_q));
  assign ark     = isr_isb ^ round_key;
  assign imc     = inv_mix_columns(ark);

  // State register
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      state_q     <= S_IDLE;
      rnd_q       <= '0;
      aes_state_q <= '0;
    end else begin
      state_q     <= state_d;
      rnd_q       <= rnd_d;
      aes_state_q <= aes_state_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d     = state_q;
    rnd_d       = rnd_q;
    aes_state_d = aes_state_q;
    case (state_q)
      S_IDLE: begin
        // in_ready is constantly high here, so in_valid alone is the handshake.
        if (in_valid) begin
          aes_state_d = in_data ^ round_key;
          rnd_d       = FIRST_RND;
          state_d     = S_ROUND;
        end
      end
      S_ROUND: begin
        aes_state_d = imc;
        rnd_d       = rnd_q - KEY_IDX_W'(1);
        if (rnd_q == KEY_IDX_W'(1)) begin
          state_d = S_FINAL;
        end
      end
      S_FINAL: begin
        aes_state_d = ark;
        state_d     = S_DONE;
      end
      S_DONE: begin
        if (out_ready) begin
          state_d = S_IDLE;
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // Output logic. key_idx depends only on state and round, so the key
  // store sees 10, 9, ..., 1, 0 for every block.
  always_comb begin
    in_ready  = 1'b0;
    out_valid = 1'b0;
    busy      = 1'b0;
    key_idx   = LAST_KEY;
    case (state_q)
      S_IDLE: begin
        in_ready = 1'b1;
        key_idx  = LAST_KEY;
      end
      S_ROUND: begin
        busy    = 1'b1;
        key_idx = rnd_q;
      end
      S_FINAL: begin
        busy    = 1'b1;
        key_idx = '0;
      end
      S_DONE: begin
        out_valid = 1'b1;
        key_idx   = '0;
      end
      default: begin
        key_idx = LAST_KEY;
      end
    endcase
  end

  assign out_data = aes_state_q;

endmodule

// File: tb/tb_aes_inv_cipher_ctrl.sv
// Directed testbench for aes_inv_cipher_ctrl. The bench builds the round-key
// store from a software key expansion, in which the forward S-box is computed
// from the GF(2^8) inverse and the affine map. It answers key_idx combinationally.
module tb_aes_inv_cipher_ctrl;

  localparam logic [127:0] KEY_C1 = 128'h000102030405060708090a0b0c0d0e0f;
  localparam logic [127:0] CT_C1  = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
  localparam logic [127:0] PT_C1  = 128'h00112233445566778899aabbccddeeff;
  localparam logic [127:0] KEY_Z  = 128'h0;
  localparam logic [127:0] CT_Z   = 128'h66e94bd4ef8a2c3b884cfa59ca342b2e;
  localparam logic [127:0] PT_Z   = 128'h0;

  logic         clk = 1'b0;
  logic         n_rst;
  logic         in_valid;
  logic         in_ready;
  logic [127:0] in_data;
  logic [3:0]   key_idx;
  logic [127:0] round_key;
  logic         out_valid;
  logic         out_ready;
  logic [127:0] out_data;
  logic         busy;

  logic [127:0] rk [0:15];
  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  assign round_key = rk[key_idx];

  aes_inv_cipher_ctrl #(.NUM_ROUNDS(10), .KEY_IDX_W(4)) dut (
    .clk       (clk),
    .n_rst     (n_rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .key_idx   (key_idx),
    .round_key (round_key),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .busy      (busy)
  );

  // ---------------- key-schedule model ----------------
  function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p, x, y;
    p = 8'h00; x = a; y = b;
    for (int i = 0; i < 8; i++) begin
      if (y[0]) p = p ^ x;
      x = {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
      y = y >> 1;
    end
    return p;
  endfunction

  function automatic logic [7:0] sbox(input logic [7:0] b);
    logic [7:0] inv;
    inv = 8'h01;
    for (int i = 0; i < 254; i++) inv = gf_mul(inv, b);
    return inv ^ {inv[6:0], inv[7]} ^ {inv[5:0], inv[7:6]} ^ {inv[4:0], inv[7:5]}
               ^ {inv[3:0], inv[7:4]} ^ 8'h63;
  endfunction

  task automatic set_key(input logic [127:0] key);
    logic [31:0] w [44];
    logic [31:0] t;
    logic [7:0]  rcon;
    rcon = 8'h01;
    for (int i = 0; i < 4; i++) w[i] = key[127-32*i -: 32];
    for (int i = 4; i < 44; i++) begin
      t = w[i-1];
      if (i % 4 == 0) begin
        t = {t[23:0], t[31:24]};
        t = {sbox(t[31:24]), sbox(t[23:16]), sbox(t[15:8]), sbox(t[7:0])} ^ {rcon, 24'h0};
        rcon = gf_mul(rcon, 8'h02);
      end
      w[i] = w[i-4] ^ t;
    end
    for (int r = 0; r < 11; r++) rk[r] = {w[4*r], w[4*r+1], w[4*r+2], w[4*r+3]};
    for (int r = 11; r < 16; r++) rk[r] = '0;
  endtask

  // ---------------- stimulus helpers (no checks) ----------------
  // Presents ct at a falling edge and returns at the falling edge after the accept edge.
  task automatic accept_block(input logic [127:0] ct);
    @(negedge clk);
    in_valid = 1'b1;
    in_data  = ct;
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    in_data  = '1;
  endtask

  // Counts falling edges from the current one until out_valid, with a bound of 40.
  task automatic wait_out(output int k);
    k = 0;
    while (out_valid !== 1'b1 && k < 40) begin
      @(negedge clk);
      k++;
    end
  endtask

  task automatic pulse_out_ready();
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    n_rst = 1'b0; in_valid = 1'b0; out_ready = 1'b0; in_data = '0;
    repeat (2) @(negedge clk);
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL reset_in_ready: got %b want 1", in_ready); end
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid: got %b want 0", out_valid); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b want 0", busy); end
    checks++; if (key_idx !== 4'd10) begin errors++; $display("FAIL reset_key_idx: got %0d want 10", key_idx); end
    checks++; if (out_data !== 128'h0) begin errors++; $display("FAIL reset_out_data: got %h want 0", out_data); end
    n_rst = 1'b1;
  endtask

  task automatic test_c1_vector();
    int k;
    set_key(KEY_C1);
    @(negedge clk);
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL c1_in_ready: got %b want 1", in_ready); end
    accept_block(CT_C1);
    wait_out(k);
    checks++; if (k != 10) begin errors++; $display("FAIL c1_latency: got %0d want 10", k); end
    checks++; if (out_data !== PT_C1) begin errors++; $display("FAIL c1_data: got %h want %h", out_data, PT_C1); end
    pulse_out_ready();
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL c1_out_valid_drop: got %b want 0", out_valid); end
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL c1_back_idle: got %b want 1", in_ready); end
  endtask

  task automatic test_zero_key();
    int k;
    set_key(KEY_Z);
    accept_block(CT_Z);
    wait_out(k);
    checks++; if (k != 10) begin errors++; $display("FAIL zero_latency: got %0d want 10", k); end
    checks++; if (out_data !== PT_Z) begin errors++; $display("FAIL zero_data: got %h want %h", out_data, PT_Z); end
    pulse_out_ready();
  endtask

  task automatic test_key_trace();
    int bad, busy_cnt, first_bad;
    logic [3:0] exp_idx;
    set_key(KEY_C1);
    @(negedge clk);
    in_valid = 1'b1; in_data = CT_C1;
    checks++; if (key_idx !== 4'd10) begin errors++; $display("FAIL trace_idle_idx: got %0d want 10", key_idx); end
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    bad = 0; busy_cnt = 0; first_bad = -1;
    for (int k = 0; k <= 10; k++) begin
      exp_idx = (k <= 8) ? 4'(9 - k) : 4'd0;
      if (busy === 1'b1) busy_cnt++;
      if (k <= 9 && key_idx !== exp_idx) begin
        bad++;
        if (first_bad < 0) first_bad = k;
      end
      if (k < 10) @(negedge clk);
    end
    checks++; if (bad != 0) begin errors++; $display("FAIL trace_key_idx: %0d wrong, first at cycle %0d, want 9..1,0", bad, first_bad); end
    checks++; if (busy_cnt != 10) begin errors++; $display("FAIL trace_busy_cycles: got %0d want 10", busy_cnt); end
    checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL trace_done: got %b want 1", out_valid); end
    pulse_out_ready();
  endtask

  task automatic test_backpressure();
    int k, bad;
    set_key(KEY_C1);
    @(negedge clk);
    in_valid = 1'b1; in_data = CT_C1;
    @(posedge clk);
    @(negedge clk);
    k = 0; bad = 0;
    while (out_valid !== 1'b1 && k < 40) begin
      in_data = {$urandom, $urandom, $urandom, $urandom};
      if (in_ready !== 1'b0) bad++;
      @(negedge clk);
      k++;
    end
    checks++; if (bad != 0) begin errors++; $display("FAIL bp_in_ready_busy: high in %0d cycles, want 0", bad); end
    checks++; if (k != 10) begin errors++; $display("FAIL bp_latency: got %0d want 10", k); end
    checks++; if (out_data !== PT_C1) begin errors++; $display("FAIL bp_data: got %h want %h", out_data, PT_C1); end
    in_data = CT_C1;
    @(negedge clk);
    checks++; if (in_ready !== 1'b0 || out_valid !== 1'b1) begin errors++; $display("FAIL bp_done_hold: in_ready=%b out_valid=%b want 0/1", in_ready, out_valid); end
    pulse_out_ready();
    checks++; if (in_ready !== 1'b1 || busy !== 1'b0) begin errors++; $display("FAIL bp_idle_after_hs: in_ready=%b busy=%b want 1/0", in_ready, busy); end
    @(negedge clk);
    checks++; if (busy !== 1'b1) begin errors++; $display("FAIL bp_second_accept: busy=%b want 1", busy); end
    in_valid = 1'b0;
    wait_out(k);
    checks++; if (k != 10 || out_data !== PT_C1) begin errors++; $display("FAIL bp_second_block: latency %0d data %h want 10 %h", k, out_data, PT_C1); end
    pulse_out_ready();
  endtask

  task automatic test_output_stall();
    int k, bad;
    set_key(KEY_C1);
    accept_block(CT_C1);
    // out_ready during ROUND must not disturb anything
    @(negedge clk); out_ready = 1'b1;
    repeat (3) @(negedge clk);
    out_ready = 1'b0;
    wait_out(k);
    checks++; if (k != 6) begin errors++; $display("FAIL stall_latency: got %0d want 6 more cycles", k); end
    checks++; if (out_data !== PT_C1) begin errors++; $display("FAIL stall_data: got %h want %h", out_data, PT_C1); end
    bad = 0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      if (out_valid !== 1'b1 || out_data !== PT_C1) bad++;
    end
    checks++; if (bad != 0) begin errors++; $display("FAIL stall_hold: %0d unstable cycles, want 0", bad); end
    pulse_out_ready();
    checks++; if (in_ready !== 1'b1 || out_valid !== 1'b0) begin errors++; $display("FAIL stall_release: in_ready=%b out_valid=%b want 1/0", in_ready, out_valid); end
  endtask

  task automatic test_back_to_back();
    int pulses, last, first, gap_bad, data_bad, k;
    set_key(KEY_C1);
    @(negedge clk);
    in_valid = 1'b1; in_data = CT_C1; out_ready = 1'b1;
    pulses = 0; last = -1; first = -1; gap_bad = 0; data_bad = 0;
    for (int n = 0; n < 40; n++) begin
      @(negedge clk);
      if (out_valid === 1'b1) begin
        if (out_data !== PT_C1) data_bad++;
        if (last >= 0 && n - last != 12) gap_bad++;
        if (first < 0) first = n;
        last = n;
        pulses++;
      end
    end
    in_valid = 1'b0; out_ready = 1'b0;
    checks++; if (pulses != 3) begin errors++; $display("FAIL b2b_pulses: got %0d want 3", pulses); end
    checks++; if (first != 10) begin errors++; $display("FAIL b2b_first: got %0d want 10", first); end
    checks++; if (gap_bad != 0) begin errors++; $display("FAIL b2b_period: %0d gaps not 12", gap_bad); end
    checks++; if (data_bad != 0) begin errors++; $display("FAIL b2b_data: %0d wrong blocks", data_bad); end
    wait_out(k);
    pulse_out_ready();
  endtask

  task automatic test_reset_mid();
    int k, ov;
    set_key(KEY_C1);
    accept_block(CT_C1);
    k = 0;
    while (key_idx !== 4'd5 && k < 20) begin
      @(negedge clk);
      k++;
    end
    checks++; if (k != 4) begin errors++; $display("FAIL rst_mid_reach_rnd5: got %0d want 4", k); end
    n_rst = 1'b0;
    #1;
    checks++; if (in_ready !== 1'b1 || busy !== 1'b0 || out_valid !== 1'b0) begin errors++; $display("FAIL rst_mid_ctrl: in_ready=%b busy=%b out_valid=%b want 1/0/0", in_ready, busy, out_valid); end
    checks++; if (key_idx !== 4'd10) begin errors++; $display("FAIL rst_mid_key_idx: got %0d want 10", key_idx); end
    checks++; if (out_data !== 128'h0) begin errors++; $display("FAIL rst_mid_data: got %h want 0", out_data); end
    @(negedge clk);
    n_rst = 1'b1;
    ov = 0;
    for (int i = 0; i < 15; i++) begin
      @(negedge clk);
      if (out_valid === 1'b1) ov++;
    end
    checks++; if (ov != 0) begin errors++; $display("FAIL rst_mid_no_out: out_valid seen %0d cycles want 0", ov); end
    accept_block(CT_C1);
    wait_out(k);
    checks++; if (k != 10 || out_data !== PT_C1) begin errors++; $display("FAIL rst_mid_fresh: latency %0d data %h want 10 %h", k, out_data, PT_C1); end
    pulse_out_ready();
  endtask

  initial begin
    for (int r = 0; r < 16; r++) rk[r] = '0;
    test_reset();
    test_c1_vector();
    test_zero_key();
    test_key_trace();
    test_backpressure();
    test_output_stall();
    test_back_to_back();
    test_reset_mid();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish, got no end want end");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/aes_inv_cipher_ctrl.md
Name: aes_inv_cipher_ctrl

Overview:
Iterative AES-128 decryption round controller. It accepts one 128-bit ciphertext block over a valid/ready handshake and fetches round keys from the external key-schedule store by index. It sequences the shared combinational inverse-round datapath (inverse_shift_rows, inverse_sub_bytes, AddRoundKey XOR, inverse_mix_columns) through 10 rounds and presents the plaintext on a held-output handshake. It sits between the key schedule RAM and the top-level decrypt wrapper; one round executes per clock.

Parameters:
NUM_ROUNDS, 10, number of cipher rounds (AES-128); key index range 0..NUM_ROUNDS
KEY_IDX_W, 4, width of round-key index

Ports:
clk  in  1  system clock, rising edge
n_rst  in  1  asynchronous active-low reset
in_valid  in  1  ciphertext valid
in_ready  out  1  controller can accept ciphertext
in_data  in  128  ciphertext, byte 0 at [127:120], column-major
key_idx  out  KEY_IDX_W  round-key index requested this cycle
round_key  in  128  round key for key_idx, combinational lookup, valid in the same cycle
out_valid  out  1  plaintext valid
out_ready  in  1  consumer accepts plaintext
out_data  out  128  plaintext; equals the state register
busy  out  1  high in ROUND or FINAL

Behaviour:
- Async reset (n_rst=0): state=IDLE, state_reg=0, round counter=0, in_ready=1, out_valid=0, busy=0, key_idx=NUM_ROUNDS.
- FSM states: IDLE, ROUND, FINAL, DONE.
- IDLE:
  - in_ready=1; key_idx=NUM_ROUNDS.
  - On in_valid&&in_ready: state_reg <= in_data ^ round_key; rnd <= NUM_ROUNDS-1; go to ROUND.
- ROUND:
  - key_idx=rnd.
  - state_reg <= InvMixColumns(InvSubBytes(InvShiftRows(state_reg)) ^ round_key).
  - rnd decrements each cycle.
  - When rnd==1, go to FINAL after this update. ROUND lasts exactly NUM_ROUNDS-1 = 9 cycles.
- FINAL:
  - key_idx=0.
  - state_reg <= InvSubBytes(InvShiftRows(state_reg)) ^ round_key. No InvMixColumns.
  - Go to DONE.
- DONE:
  - out_valid=1; out_data is held stable until out_ready.
  - On out_ready go to IDLE; out_valid drops on the next cycle.
- Latency:
  - Accept edge E0; rounds occupy E1..E9; FINAL update at E10.
  - out_valid is high after E10, i.e. 10 cycles from accept to out_valid.
  - Back-to-back throughput: one block per 12 cycles when out_ready is held high.
- in_ready=1 only in IDLE. in_valid outside IDLE is ignored and in_data is not sampled. A new block is accepted no earlier than the cycle after the DONE handshake.
- key_idx is decoded from state and rnd only, never from in_* signals. The key store sees a monotonic sequence 10,9,...,1,0 per block.
- out_ready asserted outside DONE has no effect.
- in_data changing after acceptance must not affect the result.
- Reset mid-operation (any state): immediate return to reset values. Partial state is discarded and no out_valid pulse occurs.
- All datapath arithmetic is GF(2^8) byte-wise per the inverse-round sub-blocks. The XOR is a full 128-bit XOR; no width growth.

Test Plan:
- FIPS-197 C.1 vector.
  - Stimulus: key 000102030405060708090a0b0c0d0e0f (bench key-schedule model answers key_idx); in_data=69c4e0d86a7b0430d8cdb78070b4c55a.
  - Required: out_data=00112233445566778899aabbccddeeff, with out_valid rising exactly 10 cycles after the accept edge.
- Zero key.
  - Stimulus: key all-zero; in_data=66e94bd4ef8a2c3b884cfa59ca342b2e.
  - Required: out_data=00000000000000000000000000000000.
- Key index trace.
  - Required: key_idx reads 10 (IDLE, accept), 9,8,...,1 (ROUND), 0 (FINAL); busy high exactly 10 cycles.
- Input backpressure.
  - Stimulus: in_valid held high with changing in_data while busy.
  - Required: in_ready=0 throughout; the result still matches the first block. The second block is accepted only after the DONE handshake.
- Output stall.
  - Stimulus: out_ready low for 5 cycles in DONE.
  - Required: out_valid stays 1 and out_data stays stable; one-cycle out_ready returns to IDLE with in_ready=1.
- Reset mid-operation.
  - Stimulus: n_rst pulsed low during ROUND (rnd=5).
  - Required: outputs immediately at reset values, no out_valid. A fresh C.1 block afterwards decrypts correctly.
